// File: rtl/instruction_decode.sv
// Decode stage: IF/ID register, 16x8 register file, ID/EX register, load-use stall and HALT latch.
// Optional macro WB_BYPASS_EN forwards a same-cycle writeback into the operand reads.
module instruction_decode #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       if_in,
  input  logic              flush_i,
  input  logic              wb_en_i,
  input  logic [3:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              stall_o,
  output logic              id_valid_o,
  output logic [7:0]        id_pc_o,
  output logic [3:0]        id_opcode_o,
  output logic [3:0]        id_rd_o,
  output logic [DATA_W-1:0] id_rs_val_o,
  output logic [DATA_W-1:0] id_rt_val_o,
  output logic [7:0]        id_imm_o,
  output logic              id_reg_write_o,
  output logic              id_mem_read_o,
  output logic              id_mem_write_o,
  output logic              id_branch_o,
  output logic              halt_o
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t            state, state_next;
  logic              ifid_valid;
  logic [15:0]       ifid_instr;
  logic [7:0]        ifid_pc;
  logic [DATA_W-1:0] regs [NREGS];

  logic [3:0]        op, rd, rs, rt;
  logic              uses_rt, dec_rw, dec_mr, dec_mw, dec_br;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic              load_idex;

  assign op = ifid_instr[15:12];
  assign rd = ifid_instr[11:8];
  assign rs = ifid_instr[7:4];
  assign rt = ifid_instr[3:0];

  always_comb begin
    uses_rt = 1'b0;
    dec_rw  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_br  = 1'b0;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin dec_rw = 1'b1; uses_rt = 1'b1; end
      4'h5:                   dec_rw = 1'b1;
      4'h6:                   begin dec_rw = 1'b1; dec_mr = 1'b1; end
      4'h7:                   begin dec_mw = 1'b1; uses_rt = 1'b1; end
      4'h8:                   dec_br = 1'b1;
      default:                ;
    endcase
  end

`ifdef WB_BYPASS_EN
  assign rs_val = (wb_en_i && (wb_addr_i == rs)) ? wb_data_i : regs[rs];
  assign rt_val = (wb_en_i && (wb_addr_i == rt)) ? wb_data_i : regs[rt];
`else
  assign rs_val = regs[rs];
  assign rt_val = regs[rt];
`endif

  // stall_o is the only backpressure: while high, fetch must hold if_in and IF/ID keeps
  // its contents; a bundle is consumed on any edge with stall_o low, no flush and not halted.
  assign stall_o = id_valid_o & id_mem_read_o & ifid_valid & ~flush_i &
                   ((id_rd_o == rs) | (uses_rt & (id_rd_o == rt)));

  assign load_idex = ~flush_i & ~stall_o & (state == RUN) & ifid_valid;
  assign halt_o    = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if ((state == RUN) && load_idex && (op == 4'hF)) state_next = HALTED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (flush_i || (state == HALTED)) begin
      ifid_valid <= 1'b0;
    end else if (!stall_o) begin
      ifid_valid <= 1'b1;
      ifid_instr <= if_in[23:8];
      ifid_pc    <= if_in[7:0];
    end
  end

  // Every non-load case (reset, flush, stall, halted, empty IF/ID) is a fully zeroed bubble.
  always_ff @(posedge clk) begin
    if (rst || !load_idex) begin
      id_valid_o     <= 1'b0;
      id_pc_o        <= '0;
      id_opcode_o    <= '0;
      id_rd_o        <= '0;
      id_rs_val_o    <= '0;
      id_rt_val_o    <= '0;
      id_imm_o       <= '0;
      id_reg_write_o <= 1'b0;
      id_mem_read_o  <= 1'b0;
      id_mem_write_o <= 1'b0;
      id_branch_o    <= 1'b0;
    end else begin
      id_valid_o     <= 1'b1;
      id_pc_o        <= ifid_pc;
      id_opcode_o    <= op;
      id_rd_o        <= rd;
      id_rs_val_o    <= rs_val;
      id_rt_val_o    <= rt_val;
      id_imm_o       <= ifid_instr[7:0];
      id_reg_write_o <= dec_rw;
      id_mem_read_o  <= dec_mr;
      id_mem_write_o <= dec_mw;
      id_branch_o    <= dec_br;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en_i) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed plan steps followed by randomized traffic, all
// checked against an instruction-level reference model with an expected-value queue.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] if_in = '0;
  logic        flush_i = 1'b0;
  logic        wb_en_i = 1'b0;
  logic [3:0]  wb_addr_i = '0;
  logic [7:0]  wb_data_i = '0;
  logic        stall_o, id_valid_o, id_reg_write_o, id_mem_read_o, id_mem_write_o;
  logic        id_branch_o, halt_o;
  logic [7:0]  id_pc_o, id_rs_val_o, id_rt_val_o, id_imm_o;
  logic [3:0]  id_opcode_o, id_rd_o;

  instruction_decode dut (
    .clk(clk), .rst(rst), .if_in(if_in), .flush_i(flush_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .stall_o(stall_o), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_opcode_o(id_opcode_o), .id_rd_o(id_rd_o), .id_rs_val_o(id_rs_val_o),
    .id_rt_val_o(id_rt_val_o), .id_imm_o(id_imm_o), .id_reg_write_o(id_reg_write_o),
    .id_mem_read_o(id_mem_read_o), .id_mem_write_o(id_mem_write_o),
    .id_branch_o(id_branch_o), .halt_o(halt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected queue entry: {halt, valid, pc, op, rd, rs_val, rt_val, imm, rw, mr, mw, br}
  logic [45:0] exp_q[$];

  logic        m_ifv;
  logic [15:0] m_instr;
  logic [7:0]  m_pc;
  logic [44:0] m_id;
  logic [7:0]  m_regs[16];
  logic        m_halt;
  logic        last_stall;
  logic        obs_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [44:0] decode(input logic [15:0] ins, input logic [7:0] pc,
                                         input logic [7:0] rsv, input logic [7:0] rtv);
    logic [3:0] o;
    logic rw, mr, mw, br;
    o  = ins[15:12];
    rw = (o >= 4'h1) && (o <= 4'h6);
    mr = (o == 4'h6);
    mw = (o == 4'h7);
    br = (o == 4'h8);
    return {1'b1, pc, o, ins[11:8], rsv, rtv, ins[7:0], rw, mr, mw, br};
  endfunction

  function automatic logic reads_rt(input logic [3:0] o);
    return ((o >= 4'h1) && (o <= 4'h4)) || (o == 4'h7);
  endfunction

  function automatic logic [7:0] read_reg(input logic [3:0] idx, input logic we,
                                          input logic [3:0] wa, input logic [7:0] wd);
`ifdef WB_BYPASS_EN
    if (we && wa == idx) return wd;
`endif
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    m_ifv = 1'b0; m_instr = '0; m_pc = '0; m_id = '0; m_halt = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
  endtask

  // One clock: drive inputs, check the combinational stall, advance the model, check outputs.
  task automatic step(input logic [23:0] bun, input logic fl, input logic we,
                      input logic [3:0] wa, input logic [7:0] wd, input logic r);
    logic [3:0]  rs_i, rt_i;
    logic        st, load, n_ifv, n_halt;
    logic [15:0] n_instr;
    logic [7:0]  n_pc;
    logic [44:0] n_id;
    logic [45:0] exp;
    if_in = bun; flush_i = fl; wb_en_i = we; wb_addr_i = wa; wb_data_i = wd; rst = r;
    #2;
    rs_i = m_instr[7:4];
    rt_i = m_instr[3:0];
    st = m_id[44] && m_id[2] && m_ifv && !fl &&
         (m_id[31:28] == rs_i || (reads_rt(m_instr[15:12]) && m_id[31:28] == rt_i));
    obs_stall = stall_o;
    last_stall = st;
    check("stall_o", stall_o, st);
    load = !r && !fl && !st && !m_halt && m_ifv;
    n_id = load ? decode(m_instr, m_pc, read_reg(rs_i, we, wa, wd), read_reg(rt_i, we, wa, wd))
                : '0;
    n_halt = r ? 1'b0 : (m_halt || (load && m_instr[15:12] == 4'hF));
    n_ifv = m_ifv; n_instr = m_instr; n_pc = m_pc;
    if (r) begin
      n_ifv = 1'b0; n_instr = '0; n_pc = '0;
    end else if (fl || m_halt) begin
      n_ifv = 1'b0;
    end else if (!st) begin
      n_ifv = 1'b1; n_instr = bun[23:8]; n_pc = bun[7:0];
    end
    exp_q.push_back({n_halt, n_id});
    @(posedge clk);
    #1;
    if (r) for (int i = 0; i < 16; i++) m_regs[i] = '0;
    else if (we) m_regs[wa] = wd;
    m_ifv = n_ifv; m_instr = n_instr; m_pc = n_pc; m_id = n_id; m_halt = n_halt;
    exp = exp_q.pop_front();
    check("id_bundle", {id_valid_o, id_pc_o, id_opcode_o, id_rd_o, id_rs_val_o, id_rt_val_o,
                        id_imm_o, id_reg_write_o, id_mem_read_o, id_mem_write_o, id_branch_o},
          exp[44:0]);
    check("halt_o", halt_o, exp[45]);
  endtask

  task automatic run(input logic [15:0] ins, input logic [7:0] pc);
    step({ins, pc}, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
  endtask

  task automatic wb(input logic [15:0] ins, input logic [7:0] pc,
                    input logic [3:0] wa, input logic [7:0] wd);
    step({ins, pc}, 1'b0, 1'b1, wa, wd, 1'b0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] o;
    o = 4'($urandom_range(0, 15));
    if (o == 4'hF && $urandom_range(0, 7) != 0) o = 4'h6;
    if (o > 4'h8 && o < 4'hF && $urandom_range(0, 1) == 0) o = 4'h6;
    return {o, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
  endfunction

  initial begin
    logic [15:0] fins;
    logic [7:0]  fpc;
    logic        fl, we, r;
    logic [3:0]  wa;
    logic [7:0]  wd;

    // Bring-up reset before the model is meaningful.
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // Reset state and first LDI.
    step(24'h000000, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
    check("rst_valid", id_valid_o, 1'b0);
    check("rst_halt", halt_o, 1'b0);
    run(16'h5012, 8'h00);
    run(16'h0000, 8'h01);
    check("t1_valid", id_valid_o, 1'b1);
    check("t1_opcode", id_opcode_o, 4'h5);
    check("t1_rd", id_rd_o, 4'h0);
    check("t1_imm", id_imm_o, 8'h12);
    check("t1_reg_write", id_reg_write_o, 1'b1);
    check("t1_pc", id_pc_o, 8'h00);

    // Register reads after writeback.
    wb(16'h0000, 8'h02, 4'h1, 8'h07);
    wb(16'h0000, 8'h03, 4'h2, 8'h03);
    run(16'h1312, 8'h04);
    run(16'h0000, 8'h05);
    check("t2_rs_val", id_rs_val_o, 8'h07);
    check("t2_rt_val", id_rt_val_o, 8'h03);
    check("t2_reg_write", id_reg_write_o, 1'b1);

    // Load-use hazard: one stall cycle, one bubble, ADD follows.
    run(16'h6410, 8'h06);
    run(16'h1542, 8'h07);
    run(16'h1542, 8'h07);
    check("t3_stall", obs_stall, 1'b1);
    check("t3_bubble", id_valid_o, 1'b0);
    run(16'h0000, 8'h08);
    check("t3_stall_once", obs_stall, 1'b0);
    check("t3_add_valid", id_valid_o, 1'b1);
    check("t3_add_pc", id_pc_o, 8'h07);
    check("t3_add_op", id_opcode_o, 4'h1);

    // Flush over a pending hazard.
    run(16'h6410, 8'h09);
    run(16'h1542, 8'h0A);
    step({16'h0000, 8'h0B}, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
    check("t4_stall_flush", obs_stall, 1'b0);
    check("t4_valid", id_valid_o, 1'b0);
    run(16'h0000, 8'h0C);
    check("t4_ifid_empty", id_valid_o, 1'b0);

    // HALT latches, later bundles become bubbles, reset resumes decode.
    run(16'hF000, 8'h0D);
    run(16'h0000, 8'h0E);
    check("t5_halt", halt_o, 1'b1);
    check("t5_halt_valid", id_valid_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run(16'h1312, 8'h0F);
      check("t5_halted_bubble", id_valid_o, 1'b0);
      check("t5_halt_sticky", halt_o, 1'b1);
    end
    step(24'h000000, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
    check("t5_rst_halt", halt_o, 1'b0);
    run(16'h5012, 8'h00);
    run(16'h0000, 8'h01);
    check("t5_resume", id_valid_o, 1'b1);

    // Same-cycle writeback versus read.
    wb(16'h0000, 8'h02, 4'h1, 8'h07);
    run(16'h1312, 8'h03);
    wb(16'h0000, 8'h04, 4'h1, 8'hAA);
`ifdef WB_BYPASS_EN
    check("t6_rs_bypass", id_rs_val_o, 8'hAA);
`else
    check("t6_rs_old", id_rs_val_o, 8'h07);
`endif

    // Randomized traffic with a simple fetch model that honours stall and flush.
    fpc = 8'h20;
    fins = rand_instr();
    for (int c = 0; c < 800; c++) begin
      fl = ($urandom_range(0, 9) == 0);
      we = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 4));
      wd = 8'($urandom);
      r  = (m_halt && $urandom_range(0, 3) == 0) || ($urandom_range(0, 149) == 0);
      step({fins, fpc}, fl, we, wa, wd, r);
      if (r || fl) begin
        fpc = 8'($urandom);
        fins = rand_instr();
      end else if (!last_stall) begin
        fpc = fpc + 8'd1;
        fins = rand_instr();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
